// File: rtl/mem_pkg.sv
// Shared types and constants for the LC-3 memory-port responder.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_DONE
    } mem_state_t;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 20;
    localparam logic [ADDR_W-1:0] IO_ADDR = 20'h0FFFF;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a multi-bit quasi-static input such as the board switches.
module sync2 #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d_in,
    output logic [W-1:0] d_out
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_in;
            sync_q <= meta_q;
        end
    end

    assign d_out = sync_q;

endmodule

// File: rtl/mem_responder.sv
// LC-3 memory-port responder: wait-stated word array plus switch/hex-display I/O at 0x0FFFF.
// One transaction per request; a held request is not re-triggered until both requests drop.
module mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int WAIT  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic              rd_req,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] SW,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic [DATA_W-1:0] hex_out
);

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [3:0]        WAIT_CNT = 4'(WAIT);

    mem_state_t        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              is_wr_q, is_wr_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic [DATA_W-1:0] hex_q, hex_d;

    logic              any_req;
    logic              commit;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_wr;
    logic              is_io;
    logic              is_arr;
    logic [DATA_W-1:0] arr_word;
    logic [DATA_W-1:0] sw_sync;

    logic [DATA_W-1:0] mem_array [DEPTH];

    sync2 #(
        .W(DATA_W)
    ) u_sw_sync (
        .clk  (clk),
        .reset(reset),
        .d_in (SW),
        .d_out(sw_sync)
    );

    // With zero wait states the access commits straight out of IDLE, before the latches are loaded.
    assign any_req   = rd_req | wr_req;
    assign acc_addr  = (state_q == ST_IDLE) ? mem_address : addr_q;
    assign acc_wdata = (state_q == ST_IDLE) ? mem_wdata   : wdata_q;
    assign acc_wr    = (state_q == ST_IDLE) ? wr_req      : is_wr_q;
    assign is_io     = (acc_addr == IO_ADDR);
    assign is_arr    = (acc_addr < DEPTH_A);
    assign arr_word  = mem_array[acc_addr[IDX_W-1:0]];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        is_wr_d = is_wr_q;
        rdata_d = rdata_q;
        hex_d   = hex_q;
        ready_d = 1'b0;
        commit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    addr_d  = mem_address;
                    wdata_d = mem_wdata;
                    is_wr_d = wr_req;
                    cnt_d   = WAIT_CNT;
                    if (WAIT > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_RESP;
                        commit  = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (!any_req) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!any_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Unmapped reads return zero; unmapped writes fall through both decodes and are dropped.
        if (commit) begin
            ready_d = 1'b1;
            if (acc_wr) begin
                if (is_io) begin
                    hex_d = acc_wdata;
                end
            end else if (is_io) begin
                rdata_d = sw_sync;
            end else if (is_arr) begin
                rdata_d = arr_word;
            end else begin
                rdata_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            is_wr_q <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            hex_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            is_wr_q <= is_wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            hex_q   <= hex_d;
        end
    end

    // Array contents survive reset, so this storage has no reset branch.
    always_ff @(posedge clk) begin
        if (commit && acc_wr && is_arr) begin
            mem_array[acc_addr[IDX_W-1:0]] <= acc_wdata;
        end
    end

    assign mem_rdata = rdata_q;
    assign mem_ready = ready_q;
    assign hex_out   = hex_q;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: fixed vector table, hand-written corner sequences,
// and randomized traffic against a word-array reference model; a second instance runs with WAIT=0.
module tb_mem_responder;

    localparam int DEPTH  = 256;
    localparam int WAIT_A = 2;
    localparam logic [19:0] IO_A = 20'h0FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] mem_address;
    logic [15:0] mem_wdata;
    logic [15:0] SW;
    logic        rd_a, wr_a, rd_z, wr_z;
    logic [15:0] rdata_a, rdata_z, hex_a, hex_z;
    logic        ready_a, ready_z;

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(DEPTH), .WAIT(WAIT_A)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .rd_req     (rd_a),
        .wr_req     (wr_a),
        .SW         (SW),
        .mem_rdata  (rdata_a),
        .mem_ready  (ready_a),
        .hex_out    (hex_a)
    );

    mem_responder #(.DEPTH(DEPTH), .WAIT(0)) u_dut_w0 (
        .clk        (clk),
        .reset      (reset),
        .mem_address(mem_address),
        .mem_wdata  (mem_wdata),
        .rd_req     (rd_z),
        .wr_req     (wr_z),
        .SW         (SW),
        .mem_rdata  (rdata_z),
        .mem_ready  (ready_z),
        .hex_out    (hex_z)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [19:0] addr;
        logic [15:0] data;
        logic [15:0] sw;
        bit          chk;
        logic [15:0] exp_rd;
        logic [15:0] exp_hex;
    } vec_t;

    vec_t        vecs[14];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] ref_mem [2][DEPTH];
    logic [15:0] ref_hex [2];
    logic [15:0] ref_last_rd [2];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit sel, input bit rd, input bit wr);
        if (sel) begin
            rd_z = rd;
            wr_z = wr;
        end else begin
            rd_a = rd;
            wr_a = wr;
        end
    endtask

    function automatic logic getReady(input bit sel);
        return sel ? ready_z : ready_a;
    endfunction

    function automatic logic [15:0] getRdata(input bit sel);
        return sel ? rdata_z : rdata_a;
    endfunction

    function automatic logic [15:0] getHex(input bit sel);
        return sel ? hex_z : hex_a;
    endfunction

    // Reference view of a read: I/O gives the switches, the array gives the last write, the rest zero.
    function automatic logic [15:0] refRead(input bit sel, input logic [19:0] addr);
        if (addr == IO_A)          return SW;
        else if (int'(addr) < DEPTH) return ref_mem[sel][int'(addr)];
        else                       return 16'h0000;
    endfunction

    task automatic doAccess(input bit sel, input bit rd, input bit wr, input logic [19:0] addr,
                            input logic [15:0] data, input int hold, input bit align,
                            input string tag, output logic [15:0] act_rd);
        int          lat;
        int          extra;
        bit          seen;
        logic [15:0] exp;
        if (align) begin
            @(posedge clk);
            #1;
        end
        mem_address = addr;
        mem_wdata   = data;
        applyStimulus(sel, rd, wr);
        seen = 1'b0;
        lat  = -1;
        for (int c = 1; c <= 40 && !seen; c++) begin
            @(negedge clk);
            if (getReady(sel)) begin
                seen = 1'b1;
                lat  = c - 1;
            end
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(sel ? 1 : WAIT_A + 1));
        act_rd = getRdata(sel);
        if (wr) begin
            checkOutput({tag, " rdata hold"}, 32'(act_rd), 32'(ref_last_rd[sel]));
            if (addr == IO_A)            ref_hex[sel] = data;
            else if (int'(addr) < DEPTH) ref_mem[sel][int'(addr)] = data;
        end else begin
            exp = refRead(sel, addr);
            checkOutput({tag, " rdata"}, 32'(act_rd), 32'(exp));
            ref_last_rd[sel] = exp;
        end
        checkOutput({tag, " hex"}, 32'(getHex(sel)), 32'(ref_hex[sel]));
        extra = 0;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (getReady(sel)) extra++;
        end
        if (hold > 0) checkOutput({tag, " extra ready"}, 32'(extra), 32'd0);
        applyStimulus(sel, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global timeout reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [15:0] rd_val;
        int          cnt;
        logic [19:0] a;
        int          pick;
        bit          r, w;

        vecs[0]  = '{1'b0, 1'b1, 20'h00010, 16'h1234, 16'h0000, 1'b0, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 20'h00010, 16'h0000, 16'h0000, 1'b1, 16'h1234, 16'h0000};
        vecs[2]  = '{1'b1, 1'b0, 20'h0FFFF, 16'h0000, 16'hA5A5, 1'b1, 16'hA5A5, 16'h0000};
        vecs[3]  = '{1'b0, 1'b1, 20'h0FFFF, 16'h00FF, 16'hA5A5, 1'b0, 16'h0000, 16'h00FF};
        vecs[4]  = '{1'b1, 1'b0, 20'h00010, 16'h0000, 16'hA5A5, 1'b1, 16'h1234, 16'h00FF};
        vecs[5]  = '{1'b0, 1'b1, 20'h00000, 16'h0AAA, 16'h3C3C, 1'b0, 16'h0000, 16'h00FF};
        vecs[6]  = '{1'b1, 1'b0, 20'h00200, 16'h0000, 16'h3C3C, 1'b1, 16'h0000, 16'h00FF};
        vecs[7]  = '{1'b0, 1'b1, 20'h00200, 16'hBEEF, 16'h3C3C, 1'b0, 16'h0000, 16'h00FF};
        vecs[8]  = '{1'b1, 1'b0, 20'h00000, 16'h0000, 16'h3C3C, 1'b1, 16'h0AAA, 16'h00FF};
        vecs[9]  = '{1'b0, 1'b1, 20'h1FFFF, 16'hDEAD, 16'h3C3C, 1'b0, 16'h0000, 16'h00FF};
        vecs[10] = '{1'b1, 1'b0, 20'h1FFFF, 16'h0000, 16'h3C3C, 1'b1, 16'h0000, 16'h00FF};
        vecs[11] = '{1'b0, 1'b1, 20'h000FF, 16'h5A5A, 16'h3C3C, 1'b0, 16'h0000, 16'h00FF};
        vecs[12] = '{1'b1, 1'b0, 20'h000FF, 16'h0000, 16'h3C3C, 1'b1, 16'h5A5A, 16'h00FF};
        vecs[13] = '{1'b1, 1'b0, 20'h00100, 16'h0000, 16'h3C3C, 1'b1, 16'h0000, 16'h00FF};

        reset       = 1'b0;
        mem_address = '0;
        mem_wdata   = '0;
        SW          = '0;
        rd_a = 1'b0; wr_a = 1'b0; rd_z = 1'b0; wr_z = 1'b0;
        for (int s = 0; s < 2; s++) begin
            ref_hex[s]     = 16'h0000;
            ref_last_rd[s] = 16'h0000;
            for (int i = 0; i < DEPTH; i++) ref_mem[s][i] = 16'h0000;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset ready",    32'(ready_a), 32'd0);
        checkOutput("reset rdata",    32'(rdata_a), 32'd0);
        checkOutput("reset hex",      32'(hex_a),   32'd0);
        checkOutput("reset w0 ready", 32'(ready_z), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        $display("[TB] vector table");
        for (int i = 0; i < 14; i++) begin
            SW = vecs[i].sw;
            repeat (3) @(posedge clk);
            doAccess(1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, 0, 1'b1,
                     $sformatf("vec%0d", i), rd_val);
            if (vecs[i].chk) checkOutput($sformatf("vec%0d table rdata", i), 32'(rd_val), 32'(vecs[i].exp_rd));
            checkOutput($sformatf("vec%0d table hex", i), 32'(hex_a), 32'(vecs[i].exp_hex));
        end

        $display("[TB] abort during wait states");
        doAccess(1'b0, 1'b0, 1'b1, 20'h00030, 16'h1111, 0, 1'b1, "abort pre", rd_val);
        @(posedge clk);
        #1;
        mem_address = 20'h00030;
        mem_wdata   = 16'h9999;
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 1'b0);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (ready_a) cnt++;
        end
        checkOutput("abort no ready", 32'(cnt), 32'd0);
        doAccess(1'b0, 1'b1, 1'b0, 20'h00030, 16'h0000, 10, 1'b1, "abort readback held", rd_val);
        checkOutput("abort word kept", 32'(rd_val), 32'h1111);

        $display("[TB] reset in the middle of a write");
        doAccess(1'b0, 1'b0, 1'b1, 20'h00040, 16'h2222, 0, 1'b1, "rst pre", rd_val);
        @(posedge clk);
        #1;
        mem_address = 20'h00040;
        mem_wdata   = 16'h5555;
        applyStimulus(1'b0, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("mid reset ready", 32'(ready_a), 32'd0);
        checkOutput("mid reset rdata", 32'(rdata_a), 32'd0);
        checkOutput("mid reset hex",   32'(hex_a),   32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        ref_hex[0] = 16'h0000; ref_last_rd[0] = 16'h0000;
        ref_hex[1] = 16'h0000; ref_last_rd[1] = 16'h0000;
        @(posedge clk);
        #1;
        reset = 1'b1;
        doAccess(1'b0, 1'b1, 1'b0, 20'h00040, 16'h0000, 0, 1'b0, "post reset read", rd_val);
        checkOutput("reset word kept", 32'(rd_val), 32'h2222);
        doAccess(1'b0, 1'b1, 1'b1, 20'h00050, 16'h7777, 0, 1'b1, "both req", rd_val);
        doAccess(1'b0, 1'b1, 1'b0, 20'h00050, 16'h0000, 0, 1'b1, "both req readback", rd_val);
        checkOutput("both req is write", 32'(rd_val), 32'h7777);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 32; i++) begin
            doAccess(1'b0, 1'b0, 1'b1, 20'(i), 16'($urandom), 0, 1'b1, $sformatf("fill%0d", i), rd_val);
        end
        for (int i = 0; i < 50; i++) begin
            SW = 16'($urandom);
            repeat (3) @(posedge clk);
            pick = $urandom_range(0, 9);
            if (pick <= 6)      a = 20'($urandom_range(0, 31));
            else if (pick == 7) a = IO_A;
            else begin
                a = 20'($urandom_range(DEPTH, 20'hFFFFE));
                if (a == IO_A) a = 20'h00100;
            end
            case ($urandom_range(0, 2))
                0:       begin r = 1'b1; w = 1'b0; end
                1:       begin r = 1'b0; w = 1'b1; end
                default: begin r = 1'b1; w = 1'b1; end
            endcase
            doAccess(1'b0, r, w, a, 16'($urandom), $urandom_range(0, 3), 1'b1,
                     $sformatf("rand%0d", i), rd_val);
        end

        $display("[TB] zero wait states");
        doAccess(1'b1, 1'b0, 1'b1, 20'h00050, 16'h2468, 0, 1'b1, "w0 write", rd_val);
        doAccess(1'b1, 1'b1, 1'b0, 20'h00050, 16'h0000, 0, 1'b1, "w0 read", rd_val);
        SW = 16'h6B6B;
        repeat (3) @(posedge clk);
        doAccess(1'b1, 1'b1, 1'b0, IO_A, 16'h0000, 2, 1'b1, "w0 io read", rd_val);
        doAccess(1'b1, 1'b0, 1'b1, IO_A, 16'h0C0C, 0, 1'b1, "w0 io write", rd_val);
        doAccess(1'b1, 1'b1, 1'b0, 20'h00300, 16'h0000, 0, 1'b1, "w0 unmapped", rd_val);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the LC-3 datapath's memory port: services 16-bit word reads and writes from the CPU over a request/ready handshake. It sits between the datapath's MAR/MDR outputs and on-chip storage. Accesses are backed by a synchronous word array with a programmable wait-state count. Address 0xFFFF is memory-mapped I/O: reads return the board switches, and writes load the hex-display register.

## Interface
- `DEPTH`, 256: number of 16-bit words in the backing array; must be a power of two and at most 65535.
- `WAIT`, 2: wait-state cycles inserted before `mem_ready`; range 0–15.
- `clk` input 1: single system clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `mem_address` input 20: word address from the MAR (zero-extended).
- `mem_wdata` input 16: write data from the MDR.
- `rd_req` input 1: read request; held by the CPU until `mem_ready`.
- `wr_req` input 1: write request; held by the CPU until `mem_ready`.
- `SW` input 16: board switches, asynchronous to `clk`.
- `mem_rdata` output 16: read data; valid while `mem_ready` is high and held afterwards.
- `mem_ready` output 1: one-cycle completion pulse.
- `hex_out` output 16: I/O display register.

## Operation
- **FSM states:** IDLE, WAIT, RESP, DONE.
- **IDLE:**
  - If `rd_req` or `wr_req` is high, latch the address, data and op type.
  - Load the counter with `WAIT`.
  - Go to WAIT if `WAIT` > 0, otherwise to RESP.
- **WAIT:**
  - Decrement the counter each cycle.
  - When the counter reaches 1, go to RESP.
  - If both requests are low, abort to IDLE. No write occurs and no ready pulse is issued.
- **Entering RESP:** the access commits on the edge that enters RESP.
  - A write updates the array or `hex_out`.
  - A read loads `mem_rdata`.
  - `mem_ready` is high for exactly one cycle while in RESP.
- **RESP → DONE:** unconditional.
- **DONE:** stays in DONE until both `rd_req` and `wr_req` are low, then returns to IDLE. This prevents a held request from being re-triggered.
- **Both requests high in IDLE:** treated as a write.
- **Address decode** uses the latched address:
  - 0x0FFFF is I/O.
  - 0 to DEPTH−1 is the array, indexed by the low log2(DEPTH) bits.
  - Anything else is unmapped: reads return 0x0000, writes are dropped, and `mem_ready` still pulses.
- **I/O read** returns the synchronized `SW` value.
- **Reset (any state, asynchronous assertion):**
  - Go to IDLE.
  - `mem_ready`, `mem_rdata`, `hex_out` and the counter go to 0.
  - Array contents are not reset.

## Timing
- **Latency:** with the request first high before edge k, `mem_ready` is high in the cycle after edge k+`WAIT`. This is `WAIT`+1 cycles; `WAIT`=0 gives 1 cycle.
- **Back-to-back access:** a new access may start no earlier than the cycle after requests are low in DONE. Minimum spacing is `WAIT`+3 cycles.
- **`mem_rdata` hold:** unchanged by writes; changes only on a committed read.
- **`SW` synchronizer:** 2-flop, so reads see switch values at least 2 cycles old.
- **Array read:** combinational off the latched address, registered into `mem_rdata` at RESP entry. No extra latency.
- **Reset release:** the first request is accepted on the first edge after `reset` deasserts.

## Structure
- **Shared package `mem_pkg`:**
  - state enum `mem_state_t` (IDLE, WAIT, RESP, DONE).
  - `IO_ADDR` = 20'h0FFFF.
  - `DATA_W` = 16.
  - `ADDR_W` = 20.
- **Sub-module `sync2`:** 16-bit two-flop synchronizer for `SW`, reset by the same async active-low `reset`.
- The FSM, counter, array and `hex_out` are all in `mem_responder`.

## Test plan
1. **Write then read:** after reset, write 0x1234 to 0x00010 with `WAIT`=2; `mem_ready` pulses 3 cycles after the request.
   - Then read 0x00010: `mem_rdata` = 0x1234 while `mem_ready` is high.
2. **I/O:**
   - With `SW`=0xA5A5 held for ≥3 cycles, a read of 0x0FFFF returns 0xA5A5.
   - A write of 0x00FF to 0x0FFFF sets `hex_out` = 0x00FF with the array unchanged.
3. **Unmapped address (`DEPTH`=256):**
   - A read of 0x00200 returns 0x0000.
   - A write of 0xBEEF to 0x00200 leaves array word 0x00 unchanged.
   - Both accesses pulse `mem_ready`.
4. **Abort and held request:**
   - `wr_req` dropped during WAIT: no `mem_ready` pulse and no write.
   - `rd_req` held for 10 cycles after ready: exactly one `mem_ready` pulse.
5. **Reset mid-access and simultaneous requests:**
   - Assert `reset`=0 during WAIT of a write of 0x5555: outputs return to 0 immediately and the target word keeps its old value.
   - Then assert `rd_req` and `wr_req` together with data 0x7777: a write of 0x7777 is performed.
6. **`WAIT`=0:** a read request gets `mem_ready` in the next cycle, and a second read is accepted after requests drop.
